fetch_datapath: RTL
===================

Name: fetch_datapath

Overview:
- Instruction-fetch datapath that sits directly downstream of the CPU control FSM.
- Consumes the FSM strobes (LOAD_PC, INC_PC, FETCH, LOAD_IRU, LOAD_IRL, STORE_MEM) and holds the program counter and the upper/lower instruction registers.
- Drives the unified memory port and returns OPCODE to the control FSM.
- Tracks fetch sequencing: flags protocol violations, pulses on each completed two-byte instruction and counts completed instructions.

Parameters:
- ADDR_W, 8, width of PC and memory address.
- DATA_W, 8, width of memory data, IRU, IRL and AC.
- RESET_PC, 0, PC value after reset and the LOAD_PC target before the first complete instruction.

Ports:
- CLK  in  1  clock; datapath registers update on posedge (the control FSM updates on negedge).
- RESET_N  in  1  asynchronous, active-low reset.
- LOAD_PC  in  1  load PC with the jump target.
- INC_PC  in  1  PC <= PC+1.
- FETCH  in  1  issue a memory read at PC.
- LOAD_IRU  in  1  capture MEM_RDATA into IRU.
- LOAD_IRL  in  1  capture MEM_RDATA into IRL.
- STORE_MEM  in  1  write AC to memory at address IRL.
- AC  in  DATA_W  accumulator value for stores.
- MEM_RDATA  in  DATA_W  synchronous-read memory data, valid one posedge after MEM_RE.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_RE  out  1  memory read enable.
- MEM_WE  out  1  memory write enable.
- MEM_WDATA  out  DATA_W  write data.
- PC  out  ADDR_W  program counter.
- IRU  out  DATA_W  upper instruction byte.
- IRL  out  DATA_W  lower instruction byte (operand/address).
- OPCODE  out  8  equals IRU; feeds the control FSM.
- INSTR_VALID  out  1  one-cycle pulse when an instruction completes.
- INSTR_COUNT  out  16  completed-instruction count, saturating.
- SEQ_ERR  out  1  sticky fetch-protocol violation flag.

Behaviour:
- Reset (RESET_N=0, asynchronous, takes effect immediately, including mid-fetch):
  - PC=RESET_PC; IRU=0; IRL=0; INSTR_VALID=0; INSTR_COUNT=0; SEQ_ERR=0.
  - fetch_pending=0, have_instr=0, sequencer state=EXP_U.
- Combinational memory port:
  - MEM_RE=FETCH.
  - MEM_WE=STORE_MEM & ~FETCH.
  - MEM_ADDR = (STORE_MEM & ~FETCH) ? IRL : PC.
  - MEM_WDATA=AC.
- PC update on posedge, in priority order:
  - LOAD_PC: PC <= have_instr ? IRL[ADDR_W-1:0] : RESET_PC.
  - else INC_PC: PC <= PC+1, modulo 2^ADDR_W, so FF wraps to 00.
  - LOAD_PC and INC_PC together: LOAD_PC wins and INC_PC is ignored.
- fetch_pending:
  - Set at a posedge where FETCH=1.
  - Cleared at a posedge where LOAD_IRU or LOAD_IRL=1 and FETCH=0.
- Sequencer FSM, states EXP_U and EXP_L:
  - EXP_U, LOAD_IRU=1: IRU <= MEM_RDATA, go to EXP_L.
  - EXP_L, LOAD_IRL=1: IRL <= MEM_RDATA, have_instr <= 1, INSTR_VALID pulses on the next cycle, INSTR_COUNT += 1 (holds at FFFF), go to EXP_U.
- Register capture: IRU/IRL capture on their strobe regardless of FSM state; the FSM state changes only on valid transitions.
- SEQ_ERR is set, and stays set until reset, when:
  - LOAD_IRU or LOAD_IRL is asserted with fetch_pending=0;
  - LOAD_IRL arrives in EXP_U;
  - LOAD_IRU arrives in EXP_L;
  - LOAD_IRU and LOAD_IRL are asserted in the same cycle (both registers capture);
  - FETCH and STORE_MEM are asserted together (the read wins).
- Latency:
  - Memory read: FETCH at cycle n gives data captured at cycle n+1.
  - INSTR_VALID is high in the cycle after the IRL capture.
  - OPCODE updates in the cycle after the IRU capture.

Test Plan:
- Reset with RESET_PC=0 -> PC=00, IRU=IRL=00, SEQ_ERR=0, INSTR_COUNT=0; deassert reset, no strobes for 5 cycles -> all outputs unchanged.
- Memory[00]=12, [01]=34; drive FSM sequence LOAD_PC, FETCH, LOAD_IRU+INC_PC, FETCH, LOAD_IRL+INC_PC -> IRU=12, OPCODE=12, IRL=34, PC=02, INSTR_VALID one pulse, INSTR_COUNT=1, SEQ_ERR=0.
- After the above, LOAD_PC -> PC=34; then PC=FF with INC_PC -> PC=00; LOAD_PC+INC_PC together -> PC=IRL, not IRL+1.
- LOAD_IRL without a prior FETCH, or LOAD_IRL in EXP_U -> SEQ_ERR=1 and stays 1 through 10 further correct fetches until RESET_N pulse.
- STORE_MEM with IRL=40, AC=5A -> MEM_WE=1, MEM_ADDR=40, MEM_WDATA=5A, MEM_RE=0; FETCH+STORE_MEM together -> MEM_RE=1, MEM_WE=0, SEQ_ERR=1.
- Assert RESET_N=0 between LOAD_IRU and LOAD_IRL -> immediate PC=RESET_PC, IRU=0, state EXP_U, INSTR_COUNT unchanged at 0; a subsequent full sequence completes cleanly.

Source files
------------

// File: rtl/fetch_datapath.sv
// Instruction-fetch datapath: PC, IRU/IRL, unified memory port and a
// two-byte fetch sequencer with protocol-violation tracking.
module fetch_datapath #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              LOAD_PC,
  input  logic              INC_PC,
  input  logic              FETCH,
  input  logic              LOAD_IRU,
  input  logic              LOAD_IRL,
  input  logic              STORE_MEM,
  input  logic [DATA_W-1:0] AC,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_RE,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  output logic [ADDR_W-1:0] PC,
  output logic [DATA_W-1:0] IRU,
  output logic [DATA_W-1:0] IRL,
  output logic [7:0]        OPCODE,
  output logic              INSTR_VALID,
  output logic [15:0]       INSTR_COUNT,
  output logic              SEQ_ERR
);

  typedef enum logic {EXP_U, EXP_L} seq_state_e;

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] iru_q, iru_d;
  logic [DATA_W-1:0] irl_q, irl_d;
  logic              have_instr_q, have_instr_d;
  logic              fetch_pending_q, fetch_pending_d;
  logic              instr_valid_q, instr_valid_d;
  logic [15:0]       instr_count_q, instr_count_d;
  logic              seq_err_q, seq_err_d;

  logic store_en;
  logic complete;
  logic violation;

  // A read always wins over a simultaneous store on the shared port.
  assign store_en  = STORE_MEM & ~FETCH;
  assign MEM_RE    = FETCH;
  assign MEM_WE    = store_en;
  assign MEM_ADDR  = store_en ? ADDR_W'(irl_q) : pc_q;
  assign MEM_WDATA = AC;

  assign complete  = LOAD_IRL & (state_q == EXP_L);

  assign violation = ((LOAD_IRU | LOAD_IRL) & ~fetch_pending_q)
                   | (LOAD_IRL & (state_q == EXP_U))
                   | (LOAD_IRU & (state_q == EXP_L))
                   | (LOAD_IRU & LOAD_IRL)
                   | (FETCH & STORE_MEM);

  always_comb begin
    pc_d            = pc_q;
    iru_d           = iru_q;
    irl_d           = irl_q;
    have_instr_d    = have_instr_q;
    fetch_pending_d = fetch_pending_q;
    instr_valid_d   = 1'b0;
    instr_count_d   = instr_count_q;
    seq_err_d       = seq_err_q | violation;
    state_d         = state_q;

    if (LOAD_PC) begin
      pc_d = have_instr_q ? ADDR_W'(irl_q) : RESET_PC;
    end else if (INC_PC) begin
      pc_d = pc_q + ADDR_W'(1);
    end

    // Registers capture on their strobe even when the sequencer disagrees.
    if (LOAD_IRU) iru_d = MEM_RDATA;
    if (LOAD_IRL) irl_d = MEM_RDATA;

    if (FETCH) begin
      fetch_pending_d = 1'b1;
    end else if (LOAD_IRU | LOAD_IRL) begin
      fetch_pending_d = 1'b0;
    end

    unique case (state_q)
      EXP_U: if (LOAD_IRU) state_d = EXP_L;
      EXP_L: if (LOAD_IRL) state_d = EXP_U;
      default: state_d = EXP_U;
    endcase

    if (complete) begin
      have_instr_d  = 1'b1;
      instr_valid_d = 1'b1;
      if (instr_count_q != '1) instr_count_d = instr_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= EXP_U;
      pc_q            <= RESET_PC;
      iru_q           <= '0;
      irl_q           <= '0;
      have_instr_q    <= 1'b0;
      fetch_pending_q <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_count_q   <= '0;
      seq_err_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      iru_q           <= iru_d;
      irl_q           <= irl_d;
      have_instr_q    <= have_instr_d;
      fetch_pending_q <= fetch_pending_d;
      instr_valid_q   <= instr_valid_d;
      instr_count_q   <= instr_count_d;
      seq_err_q       <= seq_err_d;
    end
  end

  assign PC          = pc_q;
  assign IRU         = iru_q;
  assign IRL         = irl_q;
  assign OPCODE      = 8'(iru_q);
  assign INSTR_VALID = instr_valid_q;
  assign INSTR_COUNT = instr_count_q;
  assign SEQ_ERR     = seq_err_q;

endmodule
